// File: rtl/zeroriscy_core2axi_ot.sv
// Core req/gnt/rvalid to single-beat AXI4 master bridge.
// Multiple in-flight transactions of one type; responses in order.
module zeroriscy_core2axi_ot #(
    parameter int                     ADDR_WIDTH      = 32,
    parameter int                     DATA_WIDTH      = 32,
    parameter int                     MAX_OUTSTANDING = 4,
    parameter int                     ID_WIDTH        = 1,
    parameter logic [ID_WIDTH-1:0]    AXI_ID          = '0,
    parameter logic [3:0]             AXI_CACHE       = 4'b0000,
    localparam int                    STRB            = DATA_WIDTH / 8,
    localparam int                    CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [STRB-1:0]       data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    output logic [CW-1:0]         outstanding_o,
    output logic [ID_WIDTH-1:0]   M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic [3:0]            M_AXI_AWCACHE,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [STRB-1:0]       M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [ID_WIDTH-1:0]   M_AXI_BID,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic [3:0]            M_AXI_ARCACHE,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RD   = 2'd1,
        MODE_WR   = 2'd2
    } mode_e;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    mode_e                 mode_q, mode_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  arvalid_q, arvalid_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB-1:0]       wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;

    logic gnt, mode_ok, slot_ok;
    logic r_acc, b_acc, resp;
    logic unused_in;

    assign unused_in = ^{M_AXI_BID, M_AXI_RID, M_AXI_RLAST,
                         M_AXI_RRESP[0], M_AXI_BRESP[0]};

    // Accept requests, track AXI handshakes and collect in-order responses.
    always_comb begin
        mode_ok = (mode_q == MODE_IDLE) ||
                  (mode_q == MODE_RD && !data_we_i) ||
                  (mode_q == MODE_WR && data_we_i);
        slot_ok = data_we_i ? (!awvalid_q && !wvalid_q) : !arvalid_q;
        gnt     = data_req_i && !reset && (count_q < MAX_CNT) &&
                  slot_ok && mode_ok;
        // Responses are only taken when they match the in-flight type.
        r_acc   = M_AXI_RVALID && !reset && (mode_q == MODE_RD);
        b_acc   = M_AXI_BVALID && !reset && (mode_q == MODE_WR);
        resp    = r_acc || b_acc;

        arvalid_d = arvalid_q && !M_AXI_ARREADY;
        awvalid_d = awvalid_q && !M_AXI_AWREADY;
        wvalid_d  = wvalid_q && !M_AXI_WREADY;
        araddr_d  = araddr_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (gnt && !data_we_i) begin
            arvalid_d = 1'b1;
            araddr_d  = data_addr_i;
        end
        if (gnt && data_we_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = data_addr_i;
            wdata_d   = data_wdata_i;
            wstrb_d   = data_be_i;
        end

        count_d = count_q;
        if (gnt && !resp)
            count_d = count_q + 1'b1;
        else if (!gnt && resp)
            count_d = count_q - 1'b1;

        mode_d = mode_q;
        if (gnt)
            mode_d = data_we_i ? MODE_WR : MODE_RD;
        else if (count_d == '0)
            mode_d = MODE_IDLE;

        rvalid_d = resp;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        if (r_acc) begin
            err_d   = M_AXI_RRESP[1];
            rdata_d = M_AXI_RDATA;
        end else if (b_acc) begin
            err_d   = M_AXI_BRESP[1];
            rdata_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_IDLE;
            count_q   <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            count_q   <= count_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign outstanding_o = count_q;

    assign M_AXI_AWID    = AXI_ID;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'($clog2(STRB));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWCACHE = AXI_CACHE;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = !reset;
    assign M_AXI_ARID    = AXI_ID;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'($clog2(STRB));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARCACHE = AXI_CACHE;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = !reset;

    // Responses with nothing of that type in flight are dropped; flag them.
    resp_unexpected_a: assert property (@(posedge clk) disable iff (reset)
        !((M_AXI_RVALID && mode_q != MODE_RD) ||
          (M_AXI_BVALID && mode_q != MODE_WR)));

endmodule

// File: tb/tb_zeroriscy_core2axi_ot.sv
// Directed bench for zeroriscy_core2axi_ot.
// Inputs change 2ns after posedge; outputs checked 1ns later.
module tb_zeroriscy_core2axi_ot;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int CW = 3;
    localparam int IW = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          data_req_i, data_gnt_o, data_rvalid_o;
    logic [AW-1:0] data_addr_i;
    logic          data_we_i;
    logic [SW-1:0] data_be_i;
    logic [DW-1:0] data_wdata_i, data_rdata_o;
    logic          data_err_o;
    logic [CW-1:0] outstanding_o;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [3:0]    awcache, arcache;
    logic          awvalid, awready, wlast, wvalid, wready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic          bvalid, bready, arvalid, arready;
    logic          rlast, rvalid, rready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    zeroriscy_core2axi_ot dut (
        .clk(clk), .reset(reset),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_addr_i(data_addr_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .data_err_o(data_err_o), .outstanding_o(outstanding_o),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
        .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
        .M_AXI_AWCACHE(awcache), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata),
        .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready), .M_AXI_ARID(arid),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
        .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
        .M_AXI_ARCACHE(arcache), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready), .M_AXI_RID(rid), .M_AXI_RDATA(rdata),
        .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_req(input logic [AW-1:0] a);
        data_req_i  = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = a;
    endtask

    initial begin
        int g;
        reset = 1'b1;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = '0;
        data_be_i = '0; data_wdata_i = '0;
        awready = 1'b0; wready = 1'b0; arready = 1'b1;
        bid = '0; bresp = '0; bvalid = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;

        // Reset state
        tick(); tick(); #1;
        chk("rst_gnt", 64'(data_gnt_o), 0);
        chk("rst_arvalid", 64'(arvalid), 0);
        chk("rst_awvalid", 64'(awvalid), 0);
        chk("rst_rvalid", 64'(data_rvalid_o), 0);
        chk("rst_out", 64'(outstanding_o), 0);
        chk("rst_rready", 64'(rready), 0);
        chk("rst_bready", 64'(bready), 0);
        chk("rst_rdata", 64'(data_rdata_o), 0);
        reset = 1'b0; data_req_i = 1'b0;
        tick(); #1;
        chk("rready_on", 64'(rready), 1);
        chk("bready_on", 64'(bready), 1);

        // 1: single read
        rd_req(32'h1000); #1;
        chk("t1_gnt", 64'(data_gnt_o), 1);
        tick(); data_req_i = 1'b0; #1;
        chk("t1_arvalid", 64'(arvalid), 1);
        chk("t1_araddr", 64'(araddr), 64'h1000);
        chk("t1_out1", 64'(outstanding_o), 1);
        chk("t1_arlen", 64'(arlen), 0);
        chk("t1_arsize", 64'(arsize), 2);
        chk("t1_arburst", 64'(arburst), 1);
        chk("t1_arcache", 64'(arcache), 0);
        chk("t1_arid", 64'(arid), 0);
        tick(); #1;
        chk("t1_arvalid_clr", 64'(arvalid), 0);
        tick(); tick();
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00; #1;
        chk("t1_rv_early", 64'(data_rvalid_o), 0);
        tick(); rvalid = 1'b0; #1;
        chk("t1_rv", 64'(data_rvalid_o), 1);
        chk("t1_rdata", 64'(data_rdata_o), 64'hDEADBEEF);
        chk("t1_err", 64'(data_err_o), 0);
        chk("t1_out0", 64'(outstanding_o), 0);
        tick(); #1;
        chk("t1_rv_once", 64'(data_rvalid_o), 0);

        // 2: six reads, limit of four
        rd_req(32'h2000);
        g = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (data_gnt_o) g++;
            tick();
        end
        #1;
        chk("t2_gnts", 64'(g), 4);
        chk("t2_out4", 64'(outstanding_o), 4);
        chk("t2_gnt_lim", 64'(data_gnt_o), 0);
        rvalid = 1'b1; rdata = 32'h11; #1;
        chk("t2_gnt_lim2", 64'(data_gnt_o), 0);
        tick(); rvalid = 1'b0; #1;
        chk("t2_out3", 64'(outstanding_o), 3);
        chk("t2_rv", 64'(data_rvalid_o), 1);
        chk("t2_gnt_back", 64'(data_gnt_o), 1);
        tick(); data_req_i = 1'b0; #1;
        chk("t2_out4b", 64'(outstanding_o), 4);
        rvalid = 1'b1; rdata = 32'h22;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("t2_drain_rv", 64'(data_rvalid_o), 1);
        end
        rvalid = 1'b0;
        chk("t2_drained", 64'(outstanding_o), 0);
        tick();

        // 3: write, W before AW, SLVERR
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h3000;
        data_wdata_i = 32'hCAFEF00D; data_be_i = 4'hA; #1;
        chk("t3_gnt", 64'(data_gnt_o), 1);
        tick(); data_req_i = 1'b0; wready = 1'b1; #1;
        chk("t3_awvalid", 64'(awvalid), 1);
        chk("t3_wvalid", 64'(wvalid), 1);
        chk("t3_wdata", 64'(wdata), 64'hCAFEF00D);
        chk("t3_wstrb", 64'(wstrb), 64'hA);
        chk("t3_wlast", 64'(wlast), 1);
        chk("t3_awsize", 64'(awsize), 2);
        tick(); wready = 1'b0; #1;
        chk("t3_wvalid_clr", 64'(wvalid), 0);
        chk("t3_aw_hold", 64'(awvalid), 1);
        tick(); #1;
        chk("t3_awaddr", 64'(awaddr), 64'h3000);
        tick(); awready = 1'b1;
        tick(); awready = 1'b0; #1;
        chk("t3_aw_clr", 64'(awvalid), 0);
        bvalid = 1'b1; bresp = 2'b10;
        tick(); bvalid = 1'b0; #1;
        chk("t3_rv", 64'(data_rvalid_o), 1);
        chk("t3_err", 64'(data_err_o), 1);
        chk("t3_rdata0", 64'(data_rdata_o), 0);
        chk("t3_out0", 64'(outstanding_o), 0);
        tick(); #1;
        chk("t3_rv_once", 64'(data_rvalid_o), 0);

        // 4: write blocked behind read
        rd_req(32'h4000);
        tick(); data_req_i = 1'b0;
        tick();
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h4400;
        data_wdata_i = 32'h01020304; data_be_i = 4'hF; #1;
        chk("t4_blk", 64'(data_gnt_o), 0);
        tick(); #1;
        chk("t4_blk2", 64'(data_gnt_o), 0);
        rvalid = 1'b1; rdata = 32'h44; #1;
        chk("t4_blk3", 64'(data_gnt_o), 0);
        tick(); rvalid = 1'b0; #1;
        chk("t4_rv", 64'(data_rvalid_o), 1);
        chk("t4_gnt", 64'(data_gnt_o), 1);
        tick(); data_req_i = 1'b0; #1;
        chk("t4_out1", 64'(outstanding_o), 1);
        chk("t4_awaddr", 64'(awaddr), 64'h4400);
        awready = 1'b1; wready = 1'b1;
        tick(); awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b00;
        tick(); bvalid = 1'b0; #1;
        chk("t4_brv", 64'(data_rvalid_o), 1);
        chk("t4_berr", 64'(data_err_o), 0);
        chk("t4_out0", 64'(outstanding_o), 0);

        // 5: response and gnt in one cycle
        rd_req(32'h5000);
        tick(); data_req_i = 1'b0;
        tick();
        rd_req(32'h5004);
        rvalid = 1'b1; rdata = 32'h12345678; #1;
        chk("t5_gnt", 64'(data_gnt_o), 1);
        tick(); data_req_i = 1'b0; rvalid = 1'b0; #1;
        chk("t5_out", 64'(outstanding_o), 1);
        chk("t5_rv", 64'(data_rvalid_o), 1);
        chk("t5_rdata", 64'(data_rdata_o), 64'h12345678);
        chk("t5_araddr", 64'(araddr), 64'h5004);
        tick(); #1;
        chk("t5_rv_once", 64'(data_rvalid_o), 0);
        rvalid = 1'b1; rdata = 32'h55AA;
        tick(); rvalid = 1'b0; #1;
        chk("t5_out0", 64'(outstanding_o), 0);

        // 6: reset with two reads in flight
        rd_req(32'h6000);
        tick(); data_req_i = 1'b0;
        tick(); rd_req(32'h6004);
        tick(); data_req_i = 1'b0; #1;
        chk("t6_out2", 64'(outstanding_o), 2);
        reset = 1'b1; rvalid = 1'b1; rdata = 32'h66;
        tick(); #1;
        chk("t6_out", 64'(outstanding_o), 0);
        chk("t6_arvalid", 64'(arvalid), 0);
        chk("t6_araddr", 64'(araddr), 0);
        chk("t6_rdata", 64'(data_rdata_o), 0);
        chk("t6_rready", 64'(rready), 0);
        chk("t6_rv", 64'(data_rvalid_o), 0);
        tick(); #1;
        chk("t6_rv_late", 64'(data_rvalid_o), 0);
        reset = 1'b0; rvalid = 1'b0;
        tick(); #1;
        chk("t6_rv_after", 64'(data_rvalid_o), 0);
        chk("t6_out_after", 64'(outstanding_o), 0);
        rd_req(32'h6100); #1;
        chk("t6_gnt", 64'(data_gnt_o), 1);
        tick(); data_req_i = 1'b0; #1;
        chk("t6_araddr2", 64'(araddr), 64'h6100);
        tick();
        rvalid = 1'b1; rdata = 32'h0BADF00D; rresp = 2'b10;
        tick(); rvalid = 1'b0; rresp = 2'b00; #1;
        chk("t6_rv2", 64'(data_rvalid_o), 1);
        chk("t6_rdata2", 64'(data_rdata_o), 64'h0BADF00D);
        chk("t6_err2", 64'(data_err_o), 1);
        chk("t6_out0", 64'(outstanding_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zeroriscy_core2axi_ot.md
Name: zeroriscy_core2axi_ot

Overview:
- Parametrised successor to the single-transaction core-to-AXI bridge on the system (ss_*) port of zeroriscy_xbar.
- Converts the core req/gnt/rvalid protocol into single-beat AXI4 master transactions.
- Adds configurable address and data width and up to MAX_OUTSTANDING in-flight transactions.
- Returns responses in order and reports AXI errors to the core.

Parameters:
ADDR_WIDTH, 32, address width on core and AXI sides
DATA_WIDTH, 32, data width (32 or 64); STRB = DATA_WIDTH/8
MAX_OUTSTANDING, 4, max accepted-but-unresponded transactions (1..16)
ID_WIDTH, 1, AXI ID width
AXI_ID, 0, constant ID driven on AW/AR
AXI_CACHE, 4'b0000, constant AWCACHE/ARCACHE value

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
data_req_i  in  1  core request
data_gnt_o  out  1  request accepted this cycle (combinational)
data_rvalid_o  out  1  response valid, one cycle per transaction
data_addr_i  in  ADDR_WIDTH  byte address
data_we_i  in  1  1=write
data_be_i  in  STRB  byte enables
data_wdata_i  in  DATA_WIDTH  write data
data_rdata_o  out  DATA_WIDTH  read data (valid with rvalid)
data_err_o  out  1  error response (valid with rvalid)
outstanding_o  out  clog2(MAX_OUTSTANDING+1)  in-flight count
M_AXI_AWID/ARID  out  ID_WIDTH  = AXI_ID
M_AXI_AWADDR/ARADDR  out  ADDR_WIDTH  registered address
M_AXI_AWLEN/ARLEN  out  8  = 0
M_AXI_AWSIZE/ARSIZE  out  3  = clog2(STRB)
M_AXI_AWBURST/ARBURST  out  2  = 2'b01
M_AXI_AWCACHE/ARCACHE  out  4  = AXI_CACHE
M_AXI_AWVALID, M_AXI_AWREADY  out, in  1  AW handshake
M_AXI_WDATA, M_AXI_WSTRB  out  DATA_WIDTH, STRB  registered write data/strobe
M_AXI_WLAST  out  1  = 1
M_AXI_WVALID, M_AXI_WREADY  out, in  1  W handshake
M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID  in  ID_WIDTH, 2, 1  write response
M_AXI_BREADY  out  1  = 1 when not in reset
M_AXI_ARVALID, M_AXI_ARREADY  out, in  1  AR handshake
M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID  in  ID_WIDTH, DATA_WIDTH, 2, 1, 1  read data
M_AXI_RREADY  out  1  = 1 when not in reset

Behaviour:
- Reset (sync, high):
  - All VALIDs, data_gnt_o, data_rvalid_o, data_err_o = 0.
  - outstanding_o = 0; BREADY = RREADY = 0.
  - Address, data and rdata registers = 0.
  - Mode register = IDLE.
  - Any in-flight AXI transaction is abandoned; responses arriving during reset are dropped.
- Mode register IDLE/RD/WR tracks the type of in-flight transactions:
  - Reads and writes are never mixed in flight, which keeps response order because AR/R and AW/B are not mutually ordered.
  - Mode returns to IDLE when the count reaches 0.
- data_gnt_o = data_req_i & ~reset & count<MAX_OUTSTANDING & channel slot free & (mode==IDLE or mode matches data_we_i).
  - Read slot free: ARVALID==0. Write slot free: AWVALID==0 & WVALID==0.
- On gnt:
  - Read: ARADDR latched, ARVALID=1 next cycle.
  - Write: AWADDR, WDATA and WSTRB latched; AWVALID and WVALID both = 1 next cycle.
  - Mode set; count+1.
- Each VALID holds with stable payload until its own READY; it clears the cycle after the handshake.
  - AW and W complete independently, in either order.
  - A new gnt of the same type is allowed only once the slot is free, so peak issue rate is 1 per 2 cycles.
- Responses:
  - R (RVALID&RREADY) or B (BVALID&BREADY) handshake at cycle N gives data_rvalid_o=1 at N+1.
  - data_rdata_o = RDATA registered at N (held otherwise; 0 after write responses).
  - data_err_o = RESP[1].
  - Response count-1 at N.
- Simultaneous gnt and response in one cycle: count unchanged. Mode stays set because count>0.
- Response with count==0 is ignored; no rvalid, no underflow. Unexpected BVALID while mode==RD is also ignored. Both are flagged by an assertion.
- count never exceeds MAX_OUTSTANDING; gnt is held low at the limit.
- RID and BID are not checked (single ID).

Test Plan:
1. Single read, ARREADY=1, RVALID 3 cycles later with RDATA=0xDEADBEEF, RRESP=0 -> gnt cycle 0, ARVALID cycle 1, data_rvalid_o=1 with rdata=0xDEADBEEF exactly 1 cycle after R handshake, err=0, outstanding 1->0.
2. MAX_OUTSTANDING=4, 6 back-to-back reads, RVALID withheld -> exactly 4 gnts; gnt low while outstanding_o=4; releasing one R restores gnt the same cycle as the decrement registers.
3. Write with WREADY 3 cycles before AWREADY, BRESP=2'b10 -> WVALID drops first, AWVALID held with stable AWADDR; one rvalid with data_err_o=1.
4. Read outstanding, then write request -> gnt stays 0 until the read response returns and mode is IDLE, then the write is granted.
5. Response handshake in the same cycle as a new same-type gnt -> outstanding_o unchanged, one rvalid next cycle.
6. reset pulsed with 2 reads in flight -> all outputs reach reset values the next cycle; late RVALID produces no data_rvalid_o; the next read proceeds normally.
